csr_access_unit: RTL
====================

# csr_access_unit

Initiator side of the CSR register-file port. Accepts one Zicsr request at a time from the execute stage and sequences the register-file read, read-modify-write computation and write-back. Returns the old CSR value for `rd`, or an illegal-instruction flag. Sits between execute and the CSR register file, and drives that file's read and write ports.

## Interface
Parameters:
- None; CSR address is 12 bits and data is 32 bits, fixed by the ISA.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  pipeline flush; aborts the in-flight request (rules below)
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit idle, request accepted when valid&ready
- req_op_i  in  2  csr_op_e: 01 RW, 10 RS, 11 RC, 00 illegal
- req_addr_i  in  12  CSR address
- req_operand_i  in  32  rs1 value, or zero-extended zimm
- req_rd_nz_i  in  1  rd != x0
- req_src_nz_i  in  1  rs1/zimm field != 0
- rsp_valid_o  out  1  response valid, held until accepted
- rsp_ready_i  in  1  consumer accepts response
- rsp_rdata_o  out  32  old CSR value; 0 when illegal or read skipped
- rsp_illegal_o  out  1  illegal CSR access
- csr_re_o  out  1  register-file read enable, one-cycle pulse
- csr_raddr_o  out  12  read address
- csr_rdata_i  in  32  read data, valid the cycle after csr_re_o
- csr_we_o  out  1  register-file write enable, one-cycle pulse
- csr_waddr_o  out  12  write address
- csr_wdata_o  out  32  write data, registered

## Operation
- FSM states: IDLE, RD, CAP, WR, RSP. `req_ready_o` = (state == IDLE).
- Accept: latch op, addr, operand, rd_nz and src_nz. Compute two flags:
  - do_read = !(op == RW && !rd_nz)
  - do_write = (op == RW) || src_nz
- Illegal when any of the following holds:
  - op == 00
  - addr is not implemented
  - do_write and addr[11:10] == 2'b11 (read-only)
- Implemented addresses:
  - 0x300 mstatus, 0x301 misa, 0x304 mie, 0x305 mtvec, 0x306 mcounteren, 0x310 mstatush, 0x320 mcountinhibit
  - 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip
  - 0xB00/0xB80 mcycle/h, 0xB02/0xB82 minstret/h
  - 0xF11–0xF14 (mvendorid, marchid, mimpid, mhartid)
- Transitions out of IDLE on accept: illegal → RSP; do_read → RD; otherwise → WR.
- RD: `csr_re_o`=1 with `csr_raddr_o`=addr. Next state CAP.
- CAP: capture `csr_rdata_i` into rdata_q. Compute wdata_q:
  - RW: operand
  - RS: rdata_q | operand
  - RC: rdata_q & ~operand
  - Next state WR if do_write, else RSP.
- WR: `csr_we_o`=1, `csr_waddr_o`=addr, `csr_wdata_o`=wdata_q (RW with read skipped uses operand). Next state RSP.
- RSP: `rsp_valid_o`=1, holding rdata_q and the illegal flag. Return to IDLE on `rsp_ready_i`.
- Flush:
  - In RD or CAP: go to IDLE, no write, no response.
  - In WR: the write still occurs this cycle, then go to IDLE with no response.
  - In RSP: drop the response and go to IDLE.
  - In IDLE: suppress acceptance that cycle (`req_ready_o` forced 0).
- Reset (any state): state IDLE, rdata_q/wdata_q/addr cleared.
  - Out of reset: all outputs 0, except `req_ready_o`=1 once state is IDLE.
  - Reset mid-operation cancels any pending write.

## Timing
- Request accepted at edge T. `rsp_valid_o` first high in cycle:
  - T+4 for a read+write
  - T+3 for a read only
  - T+2 for a write with read skipped
  - T+1 for illegal
- `csr_re_o` is high in cycle T+1. `csr_we_o` is high in cycle T+3, or T+1 when the read is skipped.
- `csr_re_o` and `csr_we_o` are never high in the same cycle. Each pulses at most once per request.
- Back-to-back: the next request can be accepted the cycle after rsp handshake.
- `rsp_*` outputs stay stable while `rsp_valid_o` && !`rsp_ready_i`.

## Structure
- Shared package `csr_pkg` holds:
  - `csr_op_e`
  - 12-bit CSR address localparams (CSR_MSTATUS etc.), also used by the register file
  - FSM state enum
- One combinational sub-module, `csr_addr_decode`: maps addr → {implemented, read_only}.

## Test plan
- CSRRS, addr 0x340, mscratch=0x0000_00F0, operand 0x0F, src_nz=1 → re at T+1, we at T+3 with wdata 0x0000_00FF, rsp_rdata 0xF0 at T+4.
- CSRRW, rd=x0, addr 0x305, operand 0x8000_0100 → no re, we at T+1 with 0x8000_0100, rsp at T+2 with rdata 0.
- CSRRS, rs1=x0, addr 0xF14 → read only, no we, rsp at T+3, illegal=0. The same with CSRRW → rsp at T+1 with illegal=1, no re or we.
- Addr 0x7C0 or op=00 → rsp_illegal_o=1 at T+1, rdata 0, no register-file access.
- CSRRC, mie=0xFFFF_FFFF, operand 0x0000_0888 → wdata 0xFFFF_F777. rsp_ready_i held low 3 cycles → outputs stable; next request accepted the cycle after ready.
- flush_i in CAP → no csr_we_o, no rsp. flush_i in WR → exactly one write, no rsp. rst_i mid-RD → IDLE with all outputs 0 and req_ready_o=1.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR definitions: Zicsr op encoding, machine-mode CSR addresses,
// access-unit FSM states and the latched request payload.
package csr_pkg;

    localparam int unsigned CSR_AW = 12;
    localparam int unsigned CSR_DW = 32;

    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } csr_state_e;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS       = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MISA          = 12'h301;
    localparam logic [CSR_AW-1:0] CSR_MIE           = 12'h304;
    localparam logic [CSR_AW-1:0] CSR_MTVEC         = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [CSR_AW-1:0] CSR_MSTATUSH      = 12'h310;
    localparam logic [CSR_AW-1:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [CSR_AW-1:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [CSR_AW-1:0] CSR_MEPC          = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE        = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL         = 12'h343;
    localparam logic [CSR_AW-1:0] CSR_MIP           = 12'h344;
    localparam logic [CSR_AW-1:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [CSR_AW-1:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [CSR_AW-1:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [CSR_AW-1:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [CSR_AW-1:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [CSR_AW-1:0] CSR_MARCHID       = 12'hF12;
    localparam logic [CSR_AW-1:0] CSR_MIMPID        = 12'hF13;
    localparam logic [CSR_AW-1:0] CSR_MHARTID       = 12'hF14;

    // Request fields kept for the lifetime of one access.
    typedef struct packed {
        csr_op_e                 op;
        logic [CSR_AW-1:0]       addr;
        logic [CSR_DW-1:0]       operand;
        logic                    do_write;
    } csr_req_t;

endpackage

// File: rtl/csr_addr_decode.sv
// Combinational CSR address decode.
//   addr_i        : CSR address
//   implemented_c : address maps to an implemented CSR
//   read_only_c   : address lies in the read-only space (addr[11:10] == 2'b11)
module csr_addr_decode
    import csr_pkg::*;
(
    input  logic [CSR_AW-1:0] addr_i,
    output logic              implemented_c,
    output logic              read_only_c
);

    always_comb begin
        implemented_c = 1'b0;
        case (addr_i)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MCOUNTEREN,
            CSR_MSTATUSH, CSR_MCOUNTINHIBIT,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID:
                implemented_c = 1'b1;
            default:
                implemented_c = 1'b0;
        endcase
        read_only_c = (addr_i[11:10] == 2'b11);
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr access sequencer between execute and the CSR register file.
// Takes one request at a time, reads the old value, computes the RW/RS/RC
// result, writes it back and returns the old value (or an illegal flag).
//   clk_i, rst_i        : clock, synchronous active-high reset
//   flush_i             : abort in-flight request / block acceptance
//   req_*               : request handshake and fields from execute
//   rsp_*               : response handshake back to execute
//   csr_re_o/raddr/rdata: register-file read port (data one cycle after re)
//   csr_we_o/waddr/wdata: register-file write port
module csr_access_unit
    import csr_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [CSR_AW-1:0] req_addr_i,
    input  logic [CSR_DW-1:0] req_operand_i,
    input  logic              req_rd_nz_i,
    input  logic              req_src_nz_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [CSR_DW-1:0] rsp_rdata_o,
    output logic              rsp_illegal_o,
    output logic              csr_re_o,
    output logic [CSR_AW-1:0] csr_raddr_o,
    input  logic [CSR_DW-1:0] csr_rdata_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [CSR_DW-1:0] csr_wdata_o
);

    csr_state_e        state_q, state_d;
    csr_req_t          req_q, req_d;
    logic [CSR_DW-1:0] rdata_q, rdata_d;
    logic [CSR_DW-1:0] wdata_q, wdata_d;
    logic              illegal_q, illegal_d;
    logic              ready_q, ready_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              implemented_c;
    logic              read_only_c;
    csr_op_e           new_op;
    logic              new_do_read;
    logic              new_do_write;
    logic              new_illegal;

    csr_addr_decode u_addr_decode (
        .addr_i        (req_addr_i),
        .implemented_c (implemented_c),
        .read_only_c   (read_only_c)
    );

    // Flush in IDLE blocks acceptance in the same cycle.
    assign req_ready_o   = ready_q && !flush_i;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_illegal_o = illegal_q;
    assign csr_re_o      = re_q;
    assign csr_raddr_o   = req_q.addr;
    assign csr_we_o      = we_q;
    assign csr_waddr_o   = req_q.addr;
    assign csr_wdata_o   = wdata_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        illegal_d = illegal_q;

        new_op       = csr_op_e'(req_op_i);
        // CSRRW with rd=x0 skips the read; RS/RC with a zero source skip the write.
        new_do_read  = !((new_op == CSR_OP_RW) && !req_rd_nz_i);
        new_do_write = (new_op == CSR_OP_RW) || req_src_nz_i;
        new_illegal  = (new_op == CSR_OP_ILL) || !implemented_c ||
                       (new_do_write && read_only_c);

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    req_d.op       = new_op;
                    req_d.addr     = req_addr_i;
                    req_d.operand  = req_operand_i;
                    req_d.do_write = new_do_write;
                    rdata_d        = '0;
                    // Write-only RW never passes CAP, so preload its write data.
                    wdata_d        = req_operand_i;
                    illegal_d      = new_illegal;
                    if (new_illegal)      state_d = ST_RSP;
                    else if (new_do_read) state_d = ST_RD;
                    else                  state_d = ST_WR;
                end
            end
            ST_RD: begin
                state_d = flush_i ? ST_IDLE : ST_CAP;
            end
            ST_CAP: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rdata_d = csr_rdata_i;
                    case (req_q.op)
                        CSR_OP_RS: wdata_d = csr_rdata_i | req_q.operand;
                        CSR_OP_RC: wdata_d = csr_rdata_i & ~req_q.operand;
                        default:   wdata_d = req_q.operand;
                    endcase
                    state_d = req_q.do_write ? ST_WR : ST_RSP;
                end
            end
            ST_WR: begin
                // The write pulse is already on the port this cycle; flush only drops the response.
                state_d = flush_i ? ST_IDLE : ST_RSP;
            end
            ST_RSP: begin
                if (flush_i || rsp_ready_i) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d     = (state_d == ST_IDLE);
        re_d        = (state_d == ST_RD);
        we_d        = (state_d == ST_WR);
        rsp_valid_d = (state_d == ST_RSP);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            illegal_q   <= 1'b0;
            ready_q     <= 1'b1;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            illegal_q   <= illegal_d;
            ready_q     <= ready_d;
            re_q        <= re_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule
